// File: rtl/simple_bus_target.sv
// Word-addressed memory target with in-order read responses through a RSP_DEPTH-entry FIFO.
// Read data is visible one cycle after acceptance; ready drops while the response FIFO is full.
module simple_bus_target #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              rready,
  output logic              err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int PTR_W     = $clog2(RSP_DEPTH);

  localparam logic [1:0]     CMD_IDLE  = 2'b00;
  localparam logic [1:0]     CMD_WRITE = 2'b01;
  localparam logic [1:0]     CMD_READ  = 2'b10;
  localparam logic [1:0]     CMD_RSV   = 2'b11;
  localparam logic [PTR_W:0] DEPTH_L   = (PTR_W + 1)'(RSP_DEPTH);

  logic [DATA_W-1:0] mem_q  [MEM_WORDS];
  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];

  logic [PTR_W:0] wptr_q, wptr_d;
  logic [PTR_W:0] rptr_q, rptr_d;
  logic [15:0]    wr_cnt_q, wr_cnt_d;
  logic [15:0]    rd_cnt_q, rd_cnt_d;
  logic           err_q, err_d;

  logic [PTR_W:0] occ;
  logic           fifo_empty;
  logic           fifo_full;
  logic           accept;
  logic           wr_acc;
  logic           push;
  logic           pop;

  // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
  assign occ        = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (occ == DEPTH_L);

  assign ready  = ~fifo_full;
  assign rvalid = ~fifo_empty;
  assign rdata  = fifo_empty ? '0 : fifo_q[rptr_q[PTR_W-1:0]];

  assign accept = ~rst & ready & (cmd != CMD_IDLE);
  assign wr_acc = accept & (cmd == CMD_WRITE);
  assign push   = accept & (cmd == CMD_READ);
  assign pop    = ~rst & rvalid & rready;

  always_comb begin
    wptr_d   = wptr_q + (PTR_W + 1)'(push);
    rptr_d   = rptr_q + (PTR_W + 1)'(pop);
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = accept & (cmd == CMD_RSV);
    if (wr_acc && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    if (push && rd_cnt_q != 16'hFFFF)   rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      mem_q[addr] <= data;
    end
  end

  // Storage needs no reset: emptied pointers hide stale entries and rdata is forced to 0.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PTR_W-1:0]] <= mem_q[addr];
  end

  assign err      = err_q;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_simple_bus_target.sv
// Directed-vector bench for simple_bus_target; expected values are hand-computed constants.
module tb_simple_bus_target;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        ready;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        rready;
  logic        err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] READ  = 2'b10;
  localparam logic [1:0] RSV   = 2'b11;

  simple_bus_target #(.ADDR_W(8), .DATA_W(8), .RSP_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .addr     (addr),
    .data     (data),
    .ready    (ready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rready   (rready),
    .err      (err),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
    cmd  = c;
    addr = a;
    data = d;
  endtask

  initial begin
    rst = 1'b1; rready = 1'b0;
    drive(IDLE, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b0;
    check("rst_ready",  ready,    1);
    check("rst_rvalid", rvalid,   0);
    check("rst_rdata",  rdata,    0);
    check("rst_err",    err,      0);
    check("rst_wrcnt",  wr_count, 0);
    check("rst_rdcnt",  rd_count, 0);

    // Write then read-after-write on the very next edge.
    rready = 1'b1;
    drive(WRITE, 8'h10, 8'hA5);
    step();
    check("raw_no_rvalid", rvalid, 0);
    drive(READ, 8'h10, 8'h00);
    step();
    check("raw_rvalid", rvalid, 1);
    check("raw_rdata",  rdata,  8'hA5);
    drive(IDLE, 8'h00, 8'h00);
    step();
    check("raw_popped", rvalid,   0);
    check("raw_wrcnt",  wr_count, 1);
    check("raw_rdcnt",  rd_count, 1);

    // Fill the FIFO with rready low; the fifth READ must stall.
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(WRITE, 8'(i), 8'(i + 8'h50));
      step();
    end
    check("pre_wrcnt", wr_count, 6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_ready%0d", i), ready, 1);
      drive(READ, 8'(i), 8'h00);
      step();
    end
    check("full_ready", ready, 0);
    drive(READ, 8'h04, 8'h00);
    step();
    check("stall_rdcnt", rd_count, 5);
    check("stall_ready", ready,    0);
    check("stall_head",  rdata,    8'h50);
    // Full with rready high: no bypass, so the READ waits one more edge.
    rready = 1'b1;
    step();
    check("nobypass_rdcnt", rd_count, 5);
    check("nobypass_ready", ready,    1);
    check("nobypass_head",  rdata,    8'h51);
    // Occupancy 3: push and pop on the same edge.
    step();
    check("pp_rdcnt", rd_count, 6);
    check("pp_head",  rdata,    8'h52);
    check("pp_ready", ready,    1);
    drive(IDLE, 8'h00, 8'h00);
    step();
    check("drain_53", rdata, 8'h53);
    step();
    check("drain_54", rdata, 8'h54);
    check("drain_v",  rvalid, 1);
    step();
    check("drain_empty", rvalid, 0);
    check("drain_zero",  rdata,  0);

    // Reserved command: err for one cycle, no side effects.
    drive(RSV, 8'h20, 8'hFF);
    step();
    check("rsv_err",    err,      1);
    check("rsv_rvalid", rvalid,   0);
    check("rsv_wrcnt",  wr_count, 6);
    check("rsv_rdcnt",  rd_count, 6);
    drive(IDLE, 8'h00, 8'h00);
    step();
    check("rsv_err_clr", err, 0);
    drive(READ, 8'h20, 8'h00);
    step();
    check("rsv_mem",   rdata,    8'h00);
    check("rsv_rv",    rvalid,   1);
    check("rsv_rdcnt2", rd_count, 7);
    drive(IDLE, 8'h00, 8'h00);
    step();

    // Reset with responses queued discards them and clears memory.
    rready = 1'b0;
    drive(READ, 8'h00, 8'h00);
    step();
    drive(READ, 8'h01, 8'h00);
    step();
    check("prerst_rvalid", rvalid, 1);
    rst = 1'b1; rready = 1'b1;
    drive(WRITE, 8'h30, 8'h77);
    step();
    rst = 1'b0;
    drive(IDLE, 8'h00, 8'h00);
    check("mrst_rvalid", rvalid,   0);
    check("mrst_ready",  ready,    1);
    check("mrst_rdcnt",  rd_count, 0);
    check("mrst_wrcnt",  wr_count, 0);
    check("mrst_rdata",  rdata,    0);
    step();
    check("mrst_stale", rvalid, 0);
    drive(READ, 8'h01, 8'h00);
    step();
    check("mrst_mem01", rdata,  8'h00);
    check("mrst_rv",    rvalid, 1);
    drive(READ, 8'h30, 8'h00);
    step();
    check("mrst_mem30", rdata, 8'h00);
    drive(IDLE, 8'h00, 8'h00);
    step();

    // wr_count saturation.
    for (int i = 0; i < 65534; i++) begin
      drive(WRITE, i[7:0], i[15:8]);
      step();
    end
    check("sat_fffe", wr_count, 16'hFFFE);
    step();
    check("sat_ffff", wr_count, 16'hFFFF);
    step();
    check("sat_hold", wr_count, 16'hFFFF);
    drive(IDLE, 8'h00, 8'h00);
    step();
    check("sat_idle", wr_count, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/simple_bus_target.md
SIMPLE_BUS_TARGET -- requirements
Module: simple_bus_target

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory holds 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter RSP_DEPTH, default 4, read-response FIFO depth; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd  input  2  bus command: 2'b00 IDLE, 2'b01 WRITE, 2'b10 READ, 2'b11 reserved.
REQ-007 addr  input  ADDR_W  command address.
REQ-008 data  input  DATA_W  write data; ignored for non-WRITE commands.
REQ-009 ready  output  1  target accepts a command on this edge when high.
REQ-010 rvalid  output  1  read response available at FIFO head.
REQ-011 rdata  output  DATA_W  read data at FIFO head; 0 when rvalid low.
REQ-012 rready  input  1  initiator consumes the head response when rvalid & rready.
REQ-013 err  output  1  one-cycle pulse: reserved command accepted.
REQ-014 wr_count  output  16  accepted WRITE count, saturating at 16'hFFFF.
REQ-015 rd_count  output  16  accepted READ count, saturating at 16'hFFFF.

Function
REQ-016 Command accepted on a rising edge iff ready is high and cmd != IDLE; otherwise cmd/addr/data are ignored.
REQ-017 ready SHALL be high iff the response FIFO holds fewer than RSP_DEPTH entries, evaluated from the current (pre-edge) occupancy.
REQ-018 Accepted WRITE: mem[addr] <= data on that edge; wr_count increments; no response entry.
REQ-019 Accepted READ: mem[addr] read and pushed into the FIFO on that edge; rd_count increments.
REQ-020 READ latency: READ accepted on edge N with FIFO empty -> rvalid high and rdata valid in the cycle after edge N.
REQ-021 WRITE on edge N followed by READ of the same addr on edge N+1 SHALL return the newly written data.
REQ-022 Responses SHALL be delivered in command order.
REQ-023 rvalid = FIFO not empty; rdata = head entry; pop on edge where rvalid & rready.
REQ-024 Push and pop on the same edge: occupancy unchanged, head advances, new entry queued at tail.
REQ-025 Full FIFO with rready high: ready stays low this cycle (no bypass); the pop frees one slot and ready rises the following cycle.
REQ-026 rready while rvalid low: no effect.
REQ-027 Accepted reserved command (2'b11): no memory or FIFO change, counters unchanged, err high for exactly the following cycle.
REQ-028 Counters hold at 16'hFFFF once reached; no wrap.
REQ-029 FIFO pointers wrap modulo RSP_DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.
REQ-030 Address uses all ADDR_W bits; no out-of-range addresses exist.

Reset
REQ-031 While rst high on an edge: FIFO emptied, all memory words cleared to 0, wr_count=0, rd_count=0, err=0; so after that edge rvalid=0, rdata=0, ready=1.
REQ-032 Commands and rready presented in a cycle where rst is high SHALL be ignored.
REQ-033 Reset mid-operation SHALL discard all queued responses; no stale response appears after rst deasserts.

Verification
REQ-034 Reset, WRITE addr 8'h10 data 8'hA5, READ 8'h10 next cycle, rready=1 -> rvalid one cycle after READ with rdata 8'hA5; wr_count=1, rd_count=1.
REQ-035 rready=0, five back-to-back READs of addrs 0..4 (pre-written 8'h00..8'h04+8'h50) -> four accepted, ready low on fifth; raise rready -> responses 8'h50..8'h53 in order; fifth READ accepted after a slot frees.
REQ-036 FIFO at 3 entries, READ accepted and pop on same edge -> occupancy stays 3, order preserved.
REQ-037 cmd=2'b11 with addr 8'h20 data 8'hFF -> err pulses one cycle, mem[8'h20] still 0, counters unchanged, no rvalid.
REQ-038 Two READs queued, rst asserted one cycle -> rvalid=0, ready=1, rd_count=0, subsequent READ of any address returns 8'h00.
REQ-039 Force wr_count to 16'hFFFE via 65534 WRITEs then two more WRITEs -> wr_count 16'hFFFF and holds.
